// File: rtl/pc_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_stage
// Description : Instruction-fetch stage. Owns the PC, drives imem reads and
//               loads the IF/ID register. Optional macro PC_ALIGN_CHECK_EN
//               forces word-aligned redirect targets and flags misalignment.
// Revision    : 1.0
// ============================================================================
module pc_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [ADDR_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    output logic [ADDR_W-1:0] if_instr,
    output logic [ADDR_W-1:0] fetch_count,
    output logic              misalign_err
);

    logic [ADDR_W-1:0] pc_q,          pc_d;
    logic              if_valid_q,    if_valid_d;
    logic [ADDR_W-1:0] if_pc_q,       if_pc_d;
    logic [ADDR_W-1:0] if_pc_plus4_q, if_pc_plus4_d;
    logic [ADDR_W-1:0] if_instr_q,    if_instr_d;
    logic [ADDR_W-1:0] fetch_count_q, fetch_count_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] redirect_tgt;

    assign pc_plus4 = pc_q + ADDR_W'(4);

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_err_q, misalign_err_d;

    assign redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign misalign_err = misalign_err_q;

    always_comb begin
        misalign_err_d = misalign_err_q;
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err_q <= 1'b0;
        end else begin
            misalign_err_q <= misalign_err_d;
        end
    end
`else
    assign redirect_tgt = redirect_pc;
    assign misalign_err = 1'b0;
`endif

    // Redirect squashes the slot and outranks stall so a taken branch is never lost.
    always_comb begin
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        if_instr_d    = if_instr_q;
        fetch_count_d = fetch_count_q;
        if (redirect_valid) begin
            pc_d       = redirect_tgt;
            if_valid_d = 1'b0;
            if_instr_d = '0;
        end else if (!stall) begin
            pc_d          = pc_plus4;
            if_valid_d    = 1'b1;
            if_pc_d       = pc_q;
            if_pc_plus4_d = pc_plus4;
            if_instr_d    = imem_rdata;
            fetch_count_d = fetch_count_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_pc_q       <= '0;
            if_pc_plus4_q <= '0;
            if_instr_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            if_instr_q    <= if_instr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign if_instr    = if_instr_q;
    assign fetch_count = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_stage
// Description : Self-checking bench for pc_fetch_stage (directed + random).
//               Honours PC_ALIGN_CHECK_EN for the misalignment expectations.
// Revision    : 1.0
// ============================================================================
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic [31:0] fetch_count;
    logic        misalign_err;

    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_rdata;
    logic        w_if_valid;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_pc_plus4;
    logic [31:0] w_if_instr;
    logic [31:0] w_fetch_count;
    logic        w_misalign_err;

    int total = 0;
    int bad   = 0;

    // Reference state, updated from the behavioural rules one edge at a time
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;
    logic        m_valid, m_err;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    assign imem_rdata   = mem(imem_addr);
    assign w_imem_rdata = mem(w_imem_addr);

    pc_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
        .if_instr(if_instr), .fetch_count(fetch_count), .misalign_err(misalign_err)
    );

    pc_fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .if_valid(w_if_valid), .if_pc(w_if_pc), .if_pc_plus4(w_if_pc_plus4),
        .if_instr(w_if_instr), .fetch_count(w_fetch_count),
        .misalign_err(w_misalign_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},     imem_addr,             m_pc);
        chk({tag, ".valid"},  {31'b0, if_valid},     {31'b0, m_valid});
        chk({tag, ".if_pc"},  if_pc,                 m_ipc);
        chk({tag, ".pc4"},    if_pc_plus4,           m_ipc4);
        chk({tag, ".instr"},  if_instr,              m_instr);
        chk({tag, ".count"},  fetch_count,           m_cnt);
        chk({tag, ".err"},    {31'b0, misalign_err}, {31'b0, m_err});
    endtask

    // Apply one clock edge of stimulus, advance the reference model, then check.
    task automatic step(input logic r, input logic s, input logic rv,
                        input logic [31:0] rp, input string tag);
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
        if (r) begin
            m_pc = 32'h0; m_valid = 1'b0; m_ipc = 32'h0; m_ipc4 = 32'h0;
            m_instr = 32'h0; m_cnt = 32'h0; m_err = 1'b0;
        end else if (rv) begin
`ifdef PC_ALIGN_CHECK_EN
            m_pc = rp & 32'hFFFF_FFFC;
            if (rp[1:0] != 2'b00) m_err = 1'b1;
`else
            m_pc = rp;
`endif
            m_valid = 1'b0;
            m_instr = 32'h0;
        end else if (!s) begin
            m_ipc   = m_pc;
            m_ipc4  = m_pc + 32'd4;
            m_instr = mem(m_pc);
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
            m_pc    = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

        // Reset for two edges
        step(1'b1, 1'b0, 1'b0, 32'h0, "reset0");
        step(1'b1, 1'b0, 1'b0, 32'h0, "reset1");
        chk("reset.instr_nop", if_instr, 32'h0);

        // Sequential fetch from address 0
        step(1'b0, 1'b0, 1'b0, 32'h0, "seq0");
        chk("seq0.pc_abs",    if_pc,    32'h0);
        chk("seq0.instr_abs", if_instr, 32'h1000);
        chk("wrap.pc",        w_imem_addr,   32'h0);
        chk("wrap.if_pc",     w_if_pc,       32'hFFFF_FFFC);
        chk("wrap.pc4",       w_if_pc_plus4, 32'h0);
        chk("wrap.valid",     {31'b0, w_if_valid}, 32'h1);
        step(1'b0, 1'b0, 1'b0, 32'h0, "seq1");
        chk("seq1.instr_abs", if_instr, 32'h1001);
        step(1'b0, 1'b0, 1'b0, 32'h0, "seq2");
        chk("seq2.instr_abs", if_instr,    32'h1002);
        chk("seq2.pc4_abs",   if_pc_plus4, 32'hC);
        chk("seq2.cnt_abs",   fetch_count, 32'd3);

        // Stall for two edges, then release
        step(1'b0, 1'b1, 1'b0, 32'h0, "stall0");
        step(1'b0, 1'b1, 1'b0, 32'h0, "stall1");
        chk("stall.cnt_abs", fetch_count, 32'd3);
        step(1'b0, 1'b0, 1'b0, 32'h0, "release");
        chk("release.if_pc_abs", if_pc, 32'hC);

        // Redirect beats a simultaneous stall
        step(1'b0, 1'b1, 1'b1, 32'h40, "redir_stall");
        chk("redir_stall.pc_abs", imem_addr, 32'h40);
        step(1'b0, 1'b0, 1'b0, 32'h0, "after_redir");
        chk("after_redir.if_pc_abs", if_pc, 32'h40);

        // Back-to-back redirects: later target wins
        step(1'b0, 1'b0, 1'b1, 32'h100, "b2b0");
        step(1'b0, 1'b0, 1'b1, 32'h200, "b2b1");
        chk("b2b.pc_abs", imem_addr, 32'h200);
        step(1'b0, 1'b0, 1'b0, 32'h0, "b2b_free");

        // Misaligned redirect target
        step(1'b0, 1'b0, 1'b1, 32'h46, "misalign");
`ifdef PC_ALIGN_CHECK_EN
        chk("misalign.pc_abs",  imem_addr, 32'h44);
        chk("misalign.err_abs", {31'b0, misalign_err}, 32'h1);
`else
        chk("misalign.pc_abs",  imem_addr, 32'h46);
        chk("misalign.err_abs", {31'b0, misalign_err}, 32'h0);
`endif
        step(1'b0, 1'b0, 1'b1, 32'h80, "aligned_after");
        step(1'b0, 1'b0, 1'b0, 32'h0, "run_after");

        // Reset during stall and during redirect
        step(1'b0, 1'b1, 1'b0, 32'h0, "pre_rst");
        step(1'b1, 1'b1, 1'b0, 32'h0, "rst_stall");
        step(1'b1, 1'b0, 1'b1, 32'h47, "rst_redir");
        step(1'b0, 1'b0, 1'b0, 32'h0, "post_rst");
        chk("post_rst.if_pc_abs", if_pc, 32'h0);

        // Randomized phase
        for (int i = 0; i < 300; i++) begin
            logic        r, s, rv;
            logic [31:0] rp;
            r  = ($urandom_range(0, 49) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 5) == 0);
            rp = $urandom;
            if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
            step(r, s, rv, rp, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
